spi_flash_arbiter: RTL
======================

SPI_FLASH_ARBITER -- requirements
Module: spi_flash_arbiter

Interface
REQ-001 Parameter GUARD_CYCLES, default 4, sets the idle sysclk cycles forced between releasing one owner and granting the next.
REQ-002 Parameter TIMEOUT_CYCLES, default 1048575, sets the maximum sysclk cycles one owner may hold the flash; width is 20 bits.
REQ-003 sysclk  in  1  internal oscillator clock (3.3-5.5 MHz); the block has one clock.
REQ-004 reset_INV  in  1  reset, synchronous, active-low.
REQ-005 enable  in  1  arbitration permitted (driven from DSP bank enable).
REQ-006 dsp_spi_cs_INV, dsp_spi_clk, dsp_spi_mosi  in  1 each  DSP requester bus.
REQ-007 cpu_spi_cs_INV, cpu_spi_clk, cpu_spi_mosi  in  1 each  CPU requester bus.
REQ-008 spi_flash_miso  in  1  flash data out.
REQ-009 spi_flash_cs_INV, spi_flash_clk, spi_flash_mosi  out  1 each  flash bus.
REQ-010 dsp_spi_miso, cpu_spi_miso  out  1 each  returned flash data.
REQ-011 grant_dsp, grant_cpu  out  1 each  registered ownership flags.
REQ-012 timeout_flag  out  1  sticky; set when an owner is forcibly revoked.
REQ-013 conflict_count  out  8  saturating count of requests refused because the other requester owned the flash.

Function
REQ-014 The block SHALL synchronise both CS_INV inputs through 2 flops; a request is a synchronised CS_INV equal to 0.
REQ-015 The FSM SHALL have the states IDLE, OWN_DSP, OWN_CPU, GUARD and WAIT_REL.
REQ-016 In IDLE with enable=1, a single request SHALL move the FSM to the corresponding OWN state on the next edge.
REQ-017 In IDLE, simultaneous requests SHALL grant the requester that did not own last; the DSP wins after reset.
REQ-018 While OWN_x, the flash bus SHALL follow requester x combinationally: flash cs = x cs_INV, flash clk = x clk, flash mosi = x mosi, and x miso = flash miso.
REQ-019 Outputs to the non-owner SHALL be miso=0, and the non-owner's bus SHALL never reach the flash.
REQ-020 When not owned, outputs SHALL be flash cs=1, flash clk=0, flash mosi=0, and both miso=0.
REQ-021 An OWN state SHALL exit to GUARD on the first cycle the owner's synchronised CS_INV is 1.
REQ-022 GUARD SHALL last exactly GUARD_CYCLES cycles, then go to IDLE; new requests are ignored during GUARD.
REQ-023 Total latency from CS release to the next grant SHALL be 2 (sync) + 1 + GUARD_CYCLES + 1 cycles.
REQ-024 The ownership counter SHALL clear on grant and increment each OWN cycle.
REQ-025 When the ownership counter reaches TIMEOUT_CYCLES, the block SHALL set timeout_flag, drop the grant and enter WAIT_REL.
REQ-026 WAIT_REL SHALL hold the flash deselected until the revoked owner's CS_INV is 1, then go to GUARD.
REQ-027 conflict_count SHALL increment once per falling edge of the non-owner's synchronised CS_INV while OWN_x, and SHALL saturate at 255.
REQ-028 enable=0 in any state SHALL force IDLE on the next edge with grants cleared and the bus deselected; enable=0 does not clear the flags or the counter.
REQ-029 The "last owner" memory SHALL update on each grant.

Reset
REQ-030 While reset_INV=0 at a sysclk edge, the block SHALL enter IDLE with grants=0, timeout_flag=0, conflict_count=0, the ownership and guard counters=0, the synchronisers=1, and last owner=CPU, so the DSP wins the first tie.
REQ-031 Reset mid-transfer SHALL deselect the flash on the same edge; no partial grant survives.

Structure
REQ-032 The FSM state encoding and the GUARD_CYCLES/TIMEOUT_CYCLES defaults SHALL live in the shared cpld package/include.
REQ-033 The block SHALL have one sub-module, cs_sync, a 2-flop synchroniser with reset value 1, instantiated per requester.

Verification
REQ-034 DSP CS low at t0 with CPU idle -> grant_dsp=1 at t0+3; flash cs/clk/mosi track DSP; cpu_spi_miso=0.
REQ-035 Both CS go low on the same cycle after reset -> DSP granted; after DSP release and guard, CPU granted exactly 2+1+4+1=8 cycles after the release.
REQ-036 CPU toggles CS 3 times while the DSP owns the flash -> conflict_count=3; 300 refused toggles -> conflict_count=255.
REQ-037 With TIMEOUT_CYCLES=16, DSP holds CS low for 40 cycles -> grant drops at cycle 16, timeout_flag=1, flash cs=1 until DSP releases, then GUARD.
REQ-038 enable deasserted mid-transfer -> next edge flash cs=1, clk=0, grants=0; reasserting enable with CS still low regrants.
REQ-039 reset_INV=0 for 1 cycle during CPU ownership -> IDLE, all outputs at reset values, and the following tie goes to the DSP.

Source files
------------

// File: rtl/spi_flash_arbiter_pkg.sv
// Shared definitions for the SPI flash arbiter: FSM encoding, timing defaults,
// counter widths and a saturating increment helper.
package spi_flash_arbiter_pkg;

  localparam int unsigned DEFAULT_GUARD_CYCLES   = 4;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1048575;
  localparam int unsigned OWN_CNT_W              = 20;
  localparam int unsigned GUARD_CNT_W            = 16;

  typedef logic [OWN_CNT_W-1:0]   own_cnt_t;
  typedef logic [GUARD_CNT_W-1:0] guard_cnt_t;
  typedef logic [7:0]             conflict_cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_OWN_DSP  = 3'd1,
    ST_OWN_CPU  = 3'd2,
    ST_GUARD    = 3'd3,
    ST_WAIT_REL = 3'd4
  } arb_state_t;

  typedef enum logic {
    OWNER_DSP = 1'b0,
    OWNER_CPU = 1'b1
  } owner_t;

  function automatic conflict_cnt_t sat_inc(input conflict_cnt_t value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/spi_flash_arbiter_cs_sync.sv
// Two-flop synchroniser for an active-low chip select; resets to the
// deselected level so a requester is never seen as active out of reset.
module cs_sync (
  input  logic sysclk,
  input  logic reset_INV,
  input  logic cs_async_INV,
  output logic cs_sync_INV
);

  logic meta_q;

  // Shift the asynchronous chip select through two flops.
  always_ff @(posedge sysclk) begin
    if (!reset_INV) begin
      meta_q      <= 1'b1;
      cs_sync_INV <= 1'b1;
    end else begin
      meta_q      <= cs_async_INV;
      cs_sync_INV <= meta_q;
    end
  end

endmodule

// File: rtl/spi_flash_arbiter.sv
// Arbitrates a single SPI flash between a DSP and a CPU requester. Ownership
// is granted on a synchronised chip select, a guard gap separates owners, an
// owner holding too long is revoked, and refused requests are counted.
module spi_flash_arbiter
  import spi_flash_arbiter_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES   = DEFAULT_GUARD_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       sysclk,
  input  logic       reset_INV,
  input  logic       enable,
  input  logic       dsp_spi_cs_INV,
  input  logic       dsp_spi_clk,
  input  logic       dsp_spi_mosi,
  input  logic       cpu_spi_cs_INV,
  input  logic       cpu_spi_clk,
  input  logic       cpu_spi_mosi,
  input  logic       spi_flash_miso,
  output logic       spi_flash_cs_INV,
  output logic       spi_flash_clk,
  output logic       spi_flash_mosi,
  output logic       dsp_spi_miso,
  output logic       cpu_spi_miso,
  output logic       grant_dsp,
  output logic       grant_cpu,
  output logic       timeout_flag,
  output logic [7:0] conflict_count
);

  localparam own_cnt_t TIMEOUT_LAST = own_cnt_t'(TIMEOUT_CYCLES - 32'd1);

  logic       dsp_cs_sync;
  logic       cpu_cs_sync;
  logic       dsp_cs_prev;
  logic       cpu_cs_prev;
  logic       dsp_req;
  logic       cpu_req;
  logic       dsp_fall;
  logic       cpu_fall;
  arb_state_t state_q;
  arb_state_t state_d;
  owner_t     last_owner;
  own_cnt_t   own_cnt;
  guard_cnt_t guard_cnt;
  logic       timeout_hit;
  logic       guard_done;
  logic       granting;
  logic       revoked_released;
  logic       owning;

  cs_sync u_dsp_sync (
    .sysclk       (sysclk),
    .reset_INV    (reset_INV),
    .cs_async_INV (dsp_spi_cs_INV),
    .cs_sync_INV  (dsp_cs_sync)
  );

  cs_sync u_cpu_sync (
    .sysclk       (sysclk),
    .reset_INV    (reset_INV),
    .cs_async_INV (cpu_spi_cs_INV),
    .cs_sync_INV  (cpu_cs_sync)
  );

  assign dsp_req          = ~dsp_cs_sync;
  assign cpu_req          = ~cpu_cs_sync;
  assign dsp_fall         = dsp_cs_prev & ~dsp_cs_sync;
  assign cpu_fall         = cpu_cs_prev & ~cpu_cs_sync;
  assign owning           = (state_q == ST_OWN_DSP) || (state_q == ST_OWN_CPU);
  assign timeout_hit      = (own_cnt == TIMEOUT_LAST);
  assign guard_done       = ({16'd0, guard_cnt} + 32'd1) >= GUARD_CYCLES;
  assign revoked_released = (last_owner == OWNER_DSP) ? dsp_cs_sync : cpu_cs_sync;
  assign granting         = (state_q == ST_IDLE) &&
                            ((state_d == ST_OWN_DSP) || (state_d == ST_OWN_CPU));

  // State register with grant flags registered alongside the next state.
  always_ff @(posedge sysclk) begin
    if (!reset_INV) begin
      state_q   <= ST_IDLE;
      grant_dsp <= 1'b0;
      grant_cpu <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_dsp <= (state_d == ST_OWN_DSP);
      grant_cpu <= (state_d == ST_OWN_CPU);
    end
  end

  // Next-state logic: dropping enable always returns to IDLE; ties go to whoever did not own last.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dsp_req && cpu_req) begin
            state_d = (last_owner == OWNER_DSP) ? ST_OWN_CPU : ST_OWN_DSP;
          end else if (dsp_req) begin
            state_d = ST_OWN_DSP;
          end else if (cpu_req) begin
            state_d = ST_OWN_CPU;
          end
        end
        ST_OWN_DSP: begin
          if (dsp_cs_sync) begin
            state_d = ST_GUARD;
          end else if (timeout_hit) begin
            state_d = ST_WAIT_REL;
          end
        end
        ST_OWN_CPU: begin
          if (cpu_cs_sync) begin
            state_d = ST_GUARD;
          end else if (timeout_hit) begin
            state_d = ST_WAIT_REL;
          end
        end
        ST_GUARD: begin
          if (guard_done) begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT_REL: begin
          if (revoked_released) begin
            state_d = ST_GUARD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Bookkeeping: ownership and guard counters, last owner, sticky timeout and refused-request count.
  always_ff @(posedge sysclk) begin
    if (!reset_INV) begin
      own_cnt        <= '0;
      guard_cnt      <= '0;
      last_owner     <= OWNER_CPU;
      timeout_flag   <= 1'b0;
      conflict_count <= '0;
      dsp_cs_prev    <= 1'b1;
      cpu_cs_prev    <= 1'b1;
    end else begin
      dsp_cs_prev <= dsp_cs_sync;
      cpu_cs_prev <= cpu_cs_sync;
      if (granting) begin
        own_cnt    <= '0;
        last_owner <= (state_d == ST_OWN_DSP) ? OWNER_DSP : OWNER_CPU;
      end else if (owning) begin
        own_cnt <= own_cnt + 20'd1;
      end
      if ((state_d == ST_GUARD) && (state_q != ST_GUARD)) begin
        guard_cnt <= '0;
      end else if (state_q == ST_GUARD) begin
        guard_cnt <= guard_cnt + 16'd1;
      end
      if (owning && (state_d == ST_WAIT_REL)) begin
        timeout_flag <= 1'b1;
      end
      if (((state_q == ST_OWN_DSP) && cpu_fall) || ((state_q == ST_OWN_CPU) && dsp_fall)) begin
        conflict_count <= sat_inc(conflict_count);
      end
    end
  end

  // Flash bus routing: only the current owner reaches the flash; everything else idles.
  always_comb begin
    spi_flash_cs_INV = 1'b1;
    spi_flash_clk    = 1'b0;
    spi_flash_mosi   = 1'b0;
    dsp_spi_miso     = 1'b0;
    cpu_spi_miso     = 1'b0;
    case (state_q)
      ST_OWN_DSP: begin
        spi_flash_cs_INV = dsp_spi_cs_INV;
        spi_flash_clk    = dsp_spi_clk;
        spi_flash_mosi   = dsp_spi_mosi;
        dsp_spi_miso     = spi_flash_miso;
      end
      ST_OWN_CPU: begin
        spi_flash_cs_INV = cpu_spi_cs_INV;
        spi_flash_clk    = cpu_spi_clk;
        spi_flash_mosi   = cpu_spi_mosi;
        cpu_spi_miso     = spi_flash_miso;
      end
      default: ;
    endcase
  end

endmodule
